pc_sequencer: RTL and testbench

//   Program counter with integrated, parametrised hardware return stack for the CPU front end.

---
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter with a bounded hardware return stack for the CPU front end.
// One opcode executes per enabled cycle; stack misuse raises sticky flags.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned VALUE_WIDTH    = 8,
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned STACK_DEPTH    = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_RET     = OPCODE_WIDTH'(1),
  parameter logic [OPCODE_WIDTH-1:0] OP_CALL    = OPCODE_WIDTH'(2),
  parameter logic [OPCODE_WIDTH-1:0] OP_JUMP    = OPCODE_WIDTH'(3),
  parameter logic [OPCODE_WIDTH-1:0] OP_IF0JUMP = OPCODE_WIDTH'(4),
  parameter logic [OPCODE_WIDTH-1:0] OP_IF1JUMP = OPCODE_WIDTH'(5),
  parameter logic [OPCODE_WIDTH-1:0] OP_RESET   = OPCODE_WIDTH'(6)
) (
  input  logic                               clock,
  input  logic                               resetN,
  input  logic                               enable,
  input  logic [OPCODE_WIDTH-1:0]            opcode,
  input  logic [VALUE_WIDTH-1:0]             instructionValue,
  input  logic [REGISTER_WIDTH-1:0]          registerValue,
  output logic [PC_WIDTH-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stackDepth,
  output logic                               stackEmpty,
  output logic                               stackFull,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_plus_one;
  logic [PC_WIDTH-1:0] target;
  logic [IW-1:0]       push_idx;
  logic [IW-1:0]       pop_idx;
  logic                do_push;

  assign pc_plus_one = pc + PC_WIDTH'(1);
  // Size cast zero-extends a narrow immediate and keeps the low bits of a wide one.
  assign target      = PC_WIDTH'(instructionValue);
  assign stackEmpty  = (stackDepth == '0);
  assign stackFull   = (stackDepth == DW'(STACK_DEPTH));
  assign push_idx    = IW'(stackDepth);
  assign pop_idx     = IW'(stackDepth - DW'(1));
  assign do_push     = enable && (opcode == OP_CALL) && !stackFull;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc         <= '0;
      stackDepth <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (enable) begin
      case (opcode)
        OP_JUMP: pc <= target;
        OP_IF0JUMP: pc <= (registerValue == '0) ? target : pc_plus_one;
        OP_IF1JUMP: pc <= (registerValue != '0) ? target : pc_plus_one;
        OP_CALL: begin
          if (!stackFull) begin
            pc         <= target;
            stackDepth <= stackDepth + DW'(1);
          end else begin
            pc       <= pc_plus_one;
            overflow <= 1'b1;
          end
        end
        OP_RET: begin
          if (!stackEmpty) begin
            pc         <= stack_mem[pop_idx];
            stackDepth <= stackDepth - DW'(1);
          end else begin
            pc        <= pc_plus_one;
            underflow <= 1'b1;
          end
        end
        OP_RESET: begin
          pc         <= '0;
          stackDepth <= '0;
          overflow   <= 1'b0;
          underflow  <= 1'b0;
        end
        default: pc <= pc_plus_one;
      endcase
    end
  end

  // Return entries need no reset; only slots below stackDepth are ever read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      stack_mem[push_idx] <= pc_plus_one;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  localparam int unsigned PCW   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] RET   = 4'd1;
  localparam logic [3:0] CALL  = 4'd2;
  localparam logic [3:0] JUMP  = 4'd3;
  localparam logic [3:0] IF0J  = 4'd4;
  localparam logic [3:0] IF1J  = 4'd5;
  localparam logic [3:0] SRST  = 4'd6;

  logic           clock;
  logic           resetN;
  logic           enable;
  logic [3:0]     opcode;
  logic [7:0]     instructionValue;
  logic [7:0]     registerValue;
  logic [PCW-1:0] pc;
  logic [DW-1:0]  stackDepth;
  logic           stackEmpty;
  logic           stackFull;
  logic           overflow;
  logic           underflow;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int m_pc;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;

  pc_sequencer #(
    .PC_WIDTH(PCW), .VALUE_WIDTH(8), .REGISTER_WIDTH(8), .OPCODE_WIDTH(4),
    .STACK_DEPTH(DEPTH),
    .OP_RET(RET), .OP_CALL(CALL), .OP_JUMP(JUMP),
    .OP_IF0JUMP(IF0J), .OP_IF1JUMP(IF1J), .OP_RESET(SRST)
  ) dut (
    .clock(clock), .resetN(resetN), .enable(enable), .opcode(opcode),
    .instructionValue(instructionValue), .registerValue(registerValue),
    .pc(pc), .stackDepth(stackDepth), .stackEmpty(stackEmpty),
    .stackFull(stackFull), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] op, input int val, input int rv);
    int pp;
    int tgt;
    if (!en) return;
    pp  = (m_pc + 1) % (1 << PCW);
    tgt = val % (1 << PCW);
    case (op)
      JUMP: m_pc = tgt;
      IF0J: m_pc = (rv == 0) ? tgt : pp;
      IF1J: m_pc = (rv != 0) ? tgt : pp;
      CALL: begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(pp);
          m_pc = tgt;
        end else begin
          m_pc  = pp;
          m_ovf = 1'b1;
        end
      end
      RET: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc  = pp;
          m_unf = 1'b1;
        end
      end
      SRST: model_reset();
      default: m_pc = pp;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc),         32'(m_pc));
    check({tag, ".depth"}, 32'(stackDepth), 32'(m_stack.size()));
    check({tag, ".empty"}, 32'(stackEmpty), 32'(m_stack.size() == 0));
    check({tag, ".full"},  32'(stackFull),  32'(m_stack.size() == DEPTH));
    check({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    check({tag, ".unf"},   32'(underflow),  32'(m_unf));
  endtask

  // Drive between edges, let the rising edge execute, sample 1 time unit later.
  task automatic step(input string tag, input bit en, input logic [3:0] op,
                      input int val, input int rv);
    @(negedge clock);
    enable           = en;
    opcode           = op;
    instructionValue = 8'(val);
    registerValue    = 8'(rv);
    @(posedge clock);
    #1;
    model_step(en, op, val, rv);
    check_all(tag);
  endtask

  initial begin
    int op_sel;
    logic [3:0] rop;
    enable = 1'b0; opcode = NOP; instructionValue = '0; registerValue = '0;
    resetN = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.pc_const", 32'(pc), 32'h0);
    @(negedge clock);
    resetN = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 5; i++) step("nop_seq", 1'b1, NOP, 0, 0);
    check("nop_seq.pc5", 32'(pc), 32'h5);

    // CALL/RET from pc=3
    step("soft_reset", 1'b1, SRST, 0, 0);
    for (int i = 0; i < 3; i++) step("to_3", 1'b1, NOP, 0, 0);
    step("call40", 1'b1, CALL, 'h40, 0);
    check("call40.pc_const", 32'(pc), 32'h40);
    step("nop41", 1'b1, NOP, 0, 0);
    step("ret", 1'b1, RET, 0, 0);
    check("ret.pc_const", 32'(pc), 32'h04);

    // Conditional jumps
    step("if0_taken", 1'b1, IF0J, 'h20, 0);
    step("if1_not",   1'b1, IF1J, 'h30, 0);
    check("if1_not.pc_const", 32'(pc), 32'h21);
    step("if1_taken", 1'b1, IF1J, 'h30, 7);
    step("if0_not",   1'b1, IF0J, 'h50, 1);

    // Fill the stack, overflow, then unwind
    for (int i = 0; i < 16; i++) step("nest_call", 1'b1, CALL, 8'h10 + 8'(i * 9), 0);
    check("nest.full_const", 32'(stackFull), 32'h1);
    step("over_call", 1'b1, CALL, 'h80, 0);
    check("over.ovf_const", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) step("unwind", 1'b1, RET, 0, 0);

    // Underflow is sticky until soft reset
    step("under_ret", 1'b1, RET, 0, 0);
    step("sticky",    1'b1, NOP, 0, 0);
    step("soft_clr",  1'b1, SRST, 0, 0);

    // PC wrap and stall
    step("jump_ff", 1'b1, JUMP, 'hFF, 0);
    step("wrap",    1'b1, NOP, 0, 0);
    check("wrap.pc_const", 32'(pc), 32'h00);
    step("stall_call", 1'b0, CALL, 'h77, 0);
    step("stall_ret",  1'b0, RET, 0, 0);

    // Asynchronous reset between edges mid-call chain
    step("chain1", 1'b1, CALL, 'h11, 0);
    step("chain2", 1'b1, CALL, 'h22, 0);
    @(negedge clock);
    enable = 1'b1; opcode = CALL; instructionValue = 8'h33;
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 resetN = 1'b1;
    @(posedge clock);
    #1;
    model_step(1'b1, CALL, 'h33, 0);
    check_all("after_rst");

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      op_sel = int'($urandom_range(0, 99));
      if      (op_sel < 30) rop = CALL;
      else if (op_sel < 55) rop = RET;
      else if (op_sel < 65) rop = JUMP;
      else if (op_sel < 73) rop = IF0J;
      else if (op_sel < 81) rop = IF1J;
      else if (op_sel < 83) rop = SRST;
      else                  rop = 4'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 9) != 0), rop,
           int'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 255)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
